// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared opcodes, condition codes, ALU-op encodings and the
//               ID/EX control word for the decode-stage control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Opcode patterns, matched against the top bits of the instruction
    localparam logic [10:0] OPC_ADDS  = 11'b10101011000;
    localparam logic [10:0] OPC_SUBS  = 11'b11101011000;
    localparam logic [10:0] OPC_AND   = 11'b10001010000;
    localparam logic [10:0] OPC_ORR   = 11'b10101010000;
    localparam logic [10:0] OPC_EOR   = 11'b11001010000;
    localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
    localparam logic [10:0] OPC_STUR  = 11'b11111000000;
    localparam logic [10:0] OPC_LSR   = 11'b11010011010;
    localparam logic [10:0] OPC_LSL   = 11'b11010011011;
    localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI  = 10'b1101000100;
    localparam logic [5:0]  OPC_B     = 6'b000101;
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OPC_BCOND = 8'b01010100;

    // B.cond condition field
    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC,
        COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT,
        COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    // ALU operations
    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_ORR   = 3'b101;
    localparam logic [2:0] ALU_EOR   = 3'b110;

    // ALU B-operand source
    localparam logic [1:0] SRC_REG   = 2'b00;
    localparam logic [1:0] SRC_IMM9  = 2'b01;
    localparam logic [1:0] SRC_IMM12 = 2'b10;

    typedef struct packed {
        logic [1:0] alu_src;
        logic [2:0] alu_op;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_write;
        logic       use_shift;
        logic       shift_left;
        logic       set_flag;
        logic       illegal;
    } ctl_word_t;

    // Bubble: no side effects, ALU idles on add
    localparam ctl_word_t CTL_BUBBLE = {SRC_REG, ALU_ADD, 7'b0000000};

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/decode_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl_unit_if
// Description : ID-stage inputs, combinational branch outputs and the ID/EX
//               control register outputs of the decode control unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_ctrl_unit_if #(
    parameter int ALUOP_W   = 3,
    parameter int ILL_CNT_W = 8
);
    logic [31:0]          instr_id;
    logic                 instr_valid;
    logic                 stall;
    logic                 flush;
    logic                 zero_id;
    logic [3:0]           flags_ex;
    logic                 reg2loc_id;
    logic                 br_taken_id;
    logic                 uncond_br_id;
    logic                 ctl_valid;
    logic [1:0]           ctl_alu_src;
    logic [ALUOP_W-1:0]   ctl_alu_op;
    logic                 ctl_mem_to_reg;
    logic                 ctl_reg_write;
    logic                 ctl_mem_write;
    logic                 ctl_use_shift;
    logic                 ctl_shift_left;
    logic                 ctl_set_flag;
    logic                 ctl_illegal;
    logic [3:0]           nzcv;
    logic [ILL_CNT_W-1:0] ill_count;

    // Pipeline side: supplies the instruction, consumes the decode results
    modport master (
        output instr_id, instr_valid, stall, flush, zero_id, flags_ex,
        input  reg2loc_id, br_taken_id, uncond_br_id,
        input  ctl_valid, ctl_alu_src, ctl_alu_op, ctl_mem_to_reg, ctl_reg_write,
        input  ctl_mem_write, ctl_use_shift, ctl_shift_left, ctl_set_flag,
        input  ctl_illegal, nzcv, ill_count
    );

    // Decode unit side
    modport slave (
        input  instr_id, instr_valid, stall, flush, zero_id, flags_ex,
        output reg2loc_id, br_taken_id, uncond_br_id,
        output ctl_valid, ctl_alu_src, ctl_alu_op, ctl_mem_to_reg, ctl_reg_write,
        output ctl_mem_write, ctl_use_shift, ctl_shift_left, ctl_set_flag,
        output ctl_illegal, nzcv, ill_count
    );
endinterface : decode_ctrl_unit_if
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Combinational B.cond evaluator. With full_bcond low only LT
//               can be taken; every other code reports not-taken.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import ctrl_pkg::*;
(
    input  wire logic [3:0] cond,
    input  wire logic [3:0] nzcv,
    input  wire logic       full_bcond,
    output logic            taken
);
    logic w_n, w_z, w_c, w_v;
    logic w_hold;

    assign {w_n, w_z, w_c, w_v} = nzcv;

    // Evaluate the condition code against the supplied flags
    always_comb begin
        w_hold = 1'b0;
        case (cond_e'(cond))
            COND_EQ: w_hold = w_z;
            COND_NE: w_hold = ~w_z;
            COND_CS: w_hold = w_c;
            COND_CC: w_hold = ~w_c;
            COND_MI: w_hold = w_n;
            COND_PL: w_hold = ~w_n;
            COND_VS: w_hold = w_v;
            COND_VC: w_hold = ~w_v;
            COND_HI: w_hold = w_c & ~w_z;
            COND_LS: w_hold = ~(w_c & ~w_z);
            COND_GE: w_hold = (w_n == w_v);
            COND_LT: w_hold = (w_n != w_v);
            COND_GT: w_hold = ~w_z & (w_n == w_v);
            COND_LE: w_hold = ~(~w_z & (w_n == w_v));
            COND_AL, COND_NV: w_hold = 1'b1;
        endcase
    end

    assign taken = (full_bcond || (cond_e'(cond) == COND_LT)) ? w_hold : 1'b0;

endmodule : cond_eval
`default_nettype wire

// File: rtl/decode_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl_unit
// Description : ID-stage decode and branch resolution with EX flag
//               forwarding, ID/EX control register with bubble insertion,
//               architectural NZCV and a saturating illegal-opcode counter.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W    = 3,
    parameter int FULL_BCOND = 1,
    parameter int CBNZ_EN    = 1,
    parameter int ILL_CNT_W  = 8
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    decode_ctrl_unit_if.slave bus
);
    ctl_word_t            w_word;
    logic                 w_reg2loc;
    logic                 w_is_b;
    logic                 w_is_cbz;
    logic                 w_is_cbnz;
    logic                 w_is_bcond;
    logic                 w_legal;
    logic                 w_issue;
    logic                 w_cond_taken;
    logic                 w_fwd;
    logic [3:0]           w_flags;

    ctl_word_t            ctl_d,       ctl_q;
    logic                 ctl_valid_d, ctl_valid_q;
    logic [3:0]           nzcv_d,      nzcv_q;
    logic [ILL_CNT_W-1:0] ill_count_d, ill_count_q;

    // Match the opcode and build the control word; anything unmatched is illegal
    always_comb begin
        w_word     = CTL_BUBBLE;
        w_reg2loc  = 1'b0;
        w_is_b     = 1'b0;
        w_is_cbz   = 1'b0;
        w_is_cbnz  = 1'b0;
        w_is_bcond = 1'b0;
        w_legal    = 1'b1;
        if (bus.instr_id[31:21] == OPC_ADDS || bus.instr_id[31:21] == OPC_SUBS) begin
            w_reg2loc        = 1'b1;
            w_word.reg_write = 1'b1;
            w_word.set_flag  = 1'b1;
            w_word.alu_op    = (bus.instr_id[31:21] == OPC_SUBS) ? ALU_SUB : ALU_ADD;
        end else if (bus.instr_id[31:21] == OPC_AND) begin
            w_reg2loc        = 1'b1;
            w_word.reg_write = 1'b1;
            w_word.alu_op    = ALU_AND;
        end else if (bus.instr_id[31:21] == OPC_ORR) begin
            w_reg2loc        = 1'b1;
            w_word.reg_write = 1'b1;
            w_word.alu_op    = ALU_ORR;
        end else if (bus.instr_id[31:21] == OPC_EOR) begin
            w_reg2loc        = 1'b1;
            w_word.reg_write = 1'b1;
            w_word.alu_op    = ALU_EOR;
        end else if (bus.instr_id[31:21] == OPC_LDUR) begin
            w_word.alu_src    = SRC_IMM9;
            w_word.mem_to_reg = 1'b1;
            w_word.reg_write  = 1'b1;
        end else if (bus.instr_id[31:21] == OPC_STUR) begin
            w_word.alu_src   = SRC_IMM9;
            w_word.mem_write = 1'b1;
        end else if (bus.instr_id[31:21] == OPC_LSR || bus.instr_id[31:21] == OPC_LSL) begin
            w_word.reg_write  = 1'b1;
            w_word.use_shift  = 1'b1;
            w_word.shift_left = (bus.instr_id[31:21] == OPC_LSL);
        end else if (bus.instr_id[31:22] == OPC_ADDI || bus.instr_id[31:22] == OPC_SUBI) begin
            w_word.alu_src   = SRC_IMM12;
            w_word.reg_write = 1'b1;
            w_word.alu_op    = (bus.instr_id[31:22] == OPC_SUBI) ? ALU_SUB : ALU_ADD;
        end else if (bus.instr_id[31:26] == OPC_B) begin
            w_is_b = 1'b1;
        end else if (bus.instr_id[31:24] == OPC_CBZ) begin
            w_is_cbz      = 1'b1;
            w_word.alu_op = ALU_PASSB;
        end else if (CBNZ_EN != 0 && bus.instr_id[31:24] == OPC_CBNZ) begin
            w_is_cbnz     = 1'b1;
            w_word.alu_op = ALU_PASSB;
        end else if (bus.instr_id[31:24] == OPC_BCOND && !bus.instr_id[4] &&
                     (FULL_BCOND != 0 || cond_e'(bus.instr_id[3:0]) == COND_LT)) begin
            w_is_bcond = 1'b1;
        end else begin
            w_legal = 1'b0;
        end
        if (!w_legal) begin
            w_word.illegal = 1'b1;
        end
    end

    assign w_issue = bus.instr_valid & ~bus.stall & ~bus.flush;

    // A flag setter sitting in EX has not reached nzcv yet, so take its flags directly
    assign w_fwd   = ctl_valid_q & ctl_q.set_flag;
    assign w_flags = w_fwd ? bus.flags_ex : nzcv_q;

    cond_eval u_cond_eval (
        .cond       (bus.instr_id[3:0]),
        .nzcv       (w_flags),
        .full_bcond (FULL_BCOND != 0),
        .taken      (w_cond_taken)
    );

    assign bus.reg2loc_id   = w_reg2loc;
    assign bus.uncond_br_id = w_is_b;
    assign bus.br_taken_id  = w_issue & (w_is_b |
                                         (w_is_cbz   &  bus.zero_id) |
                                         (w_is_cbnz  & ~bus.zero_id) |
                                         (w_is_bcond &  w_cond_taken));

    // Next state: issue or bubble into EX, flag capture, saturating illegal count
    always_comb begin
        ctl_d       = w_issue ? w_word : CTL_BUBBLE;
        ctl_valid_d = w_issue;
        nzcv_d      = w_fwd ? bus.flags_ex : nzcv_q;
        ill_count_d = ill_count_q;
        if (w_issue && !w_legal && ill_count_q != {ILL_CNT_W{1'b1}}) begin
            ill_count_d = ill_count_q + ILL_CNT_W'(1);
        end
    end

    // ID/EX control register, flag register and counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctl_q       <= CTL_BUBBLE;
            ctl_valid_q <= 1'b0;
            nzcv_q      <= 4'b0000;
            ill_count_q <= '0;
        end else begin
            ctl_q       <= ctl_d;
            ctl_valid_q <= ctl_valid_d;
            nzcv_q      <= nzcv_d;
            ill_count_q <= ill_count_d;
        end
    end

    assign bus.ctl_valid      = ctl_valid_q;
    assign bus.ctl_alu_src    = ctl_q.alu_src;
    assign bus.ctl_mem_to_reg = ctl_q.mem_to_reg;
    assign bus.ctl_reg_write  = ctl_q.reg_write;
    assign bus.ctl_mem_write  = ctl_q.mem_write;
    assign bus.ctl_use_shift  = ctl_q.use_shift;
    assign bus.ctl_shift_left = ctl_q.shift_left;
    assign bus.ctl_set_flag   = ctl_q.set_flag;
    assign bus.ctl_illegal    = ctl_q.illegal;
    assign bus.nzcv           = nzcv_q;
    assign bus.ill_count      = ill_count_q;

    // Zero-extend the internal 3-bit ALU op to the configured port width
    if (ALUOP_W > 3) begin : g_alu_op_wide
        assign bus.ctl_alu_op = {{(ALUOP_W-3){1'b0}}, ctl_q.alu_op};
    end else begin : g_alu_op_min
        assign bus.ctl_alu_op = ctl_q.alu_op;
    end

endmodule : decode_ctrl_unit
`default_nettype wire

// File: tb/tb_decode_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_ctrl_unit
// Description : Self-checking bench for decode_ctrl_unit. One instance uses
//               the full B.cond set, a second has FULL_BCOND=0, CBNZ_EN=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_ctrl_unit;

    localparam logic [31:0] I_ADDS = 32'hAB020041;
    localparam logic [31:0] I_SUBS = 32'hEB020023;
    localparam logic [31:0] I_AND  = 32'h8A020023;
    localparam logic [31:0] I_ORR  = 32'hAA020023;
    localparam logic [31:0] I_EOR  = 32'hCA020023;
    localparam logic [31:0] I_LDUR = 32'hF8400081;
    localparam logic [31:0] I_STUR = 32'hF8000081;
    localparam logic [31:0] I_LSR  = 32'hD3410C41;
    localparam logic [31:0] I_LSL  = 32'hD3610C41;
    localparam logic [31:0] I_ADDI = 32'h91000421;
    localparam logic [31:0] I_SUBI = 32'hD1000421;
    localparam logic [31:0] I_B    = 32'h14000010;
    localparam logic [31:0] I_CBZ  = 32'hB4000041;
    localparam logic [31:0] I_CBNZ = 32'hB5000041;
    localparam logic [31:0] I_BC   = 32'h54000040;
    localparam logic [31:0] I_BC4  = 32'h54000050;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    decode_ctrl_unit_if #(.ALUOP_W(3), .ILL_CNT_W(8)) bus0 ();
    decode_ctrl_unit_if #(.ALUOP_W(3), .ILL_CNT_W(8)) bus1 ();

    decode_ctrl_unit #(.ALUOP_W(3), .FULL_BCOND(1), .CBNZ_EN(1), .ILL_CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    decode_ctrl_unit #(.ALUOP_W(3), .FULL_BCOND(0), .CBNZ_EN(0), .ILL_CNT_W(8)) dut_lt (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    // idout = {reg2loc, br_taken, uncond}; ctl = {valid, src, op, m2r, rw, mw, us, sl, sf, ill}
    typedef struct {
        logic [31:0] instr;
        logic        v, st, fl, z;
        logic [3:0]  fx;
        logic [2:0]  idout;
        logic [12:0] ctl;
        logic [3:0]  nzcv;
        logic [7:0]  ill;
    } vec_t;

    typedef struct {
        logic [12:0] ctl;
        logic [3:0]  nzcv;
        logic [7:0]  ill;
        int          sel;
        int          idx;
    } exp_t;

    vec_t tbl[$];
    vec_t tb_lt[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [12:0] BUB, NOPW, ILLW, ADDSW, SUBSW, CBW, LDURW, STURW, LSLW, LSRW;
    logic [12:0] ANDW, ORRW, EORW, ADDIW, SUBIW;

    function automatic logic [12:0] cw(input logic v, input logic [1:0] src,
                                       input logic [2:0] op, input logic [6:0] f);
        return {v, src, op, f};
    endfunction

    function automatic vec_t mk(input logic [31:0] i, input logic v, input logic st,
                                input logic fl, input logic z, input logic [3:0] fx,
                                input logic [2:0] idout, input logic [12:0] ctl,
                                input logic [3:0] nz, input logic [7:0] ill);
        vec_t r;
        r.instr = i; r.v = v; r.st = st; r.fl = fl; r.z = z; r.fx = fx;
        r.idout = idout; r.ctl = ctl; r.nzcv = nz; r.ill = ill;
        return r;
    endfunction

    function automatic logic [2:0] act_id(input int sel);
        if (sel == 0) return {bus0.reg2loc_id, bus0.br_taken_id, bus0.uncond_br_id};
        return {bus1.reg2loc_id, bus1.br_taken_id, bus1.uncond_br_id};
    endfunction

    function automatic logic [12:0] act_ctl(input int sel);
        if (sel == 0)
            return {bus0.ctl_valid, bus0.ctl_alu_src, bus0.ctl_alu_op, bus0.ctl_mem_to_reg,
                    bus0.ctl_reg_write, bus0.ctl_mem_write, bus0.ctl_use_shift,
                    bus0.ctl_shift_left, bus0.ctl_set_flag, bus0.ctl_illegal};
        return {bus1.ctl_valid, bus1.ctl_alu_src, bus1.ctl_alu_op, bus1.ctl_mem_to_reg,
                bus1.ctl_reg_write, bus1.ctl_mem_write, bus1.ctl_use_shift,
                bus1.ctl_shift_left, bus1.ctl_set_flag, bus1.ctl_illegal};
    endfunction

    function automatic logic [3:0] act_nzcv(input int sel);
        return (sel == 0) ? bus0.nzcv : bus1.nzcv;
    endfunction

    function automatic logic [7:0] act_ill(input int sel);
        return (sel == 0) ? bus0.ill_count : bus1.ill_count;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] i, input logic v, input logic st,
                          input logic fl, input logic z, input logic [3:0] fx);
        bus0.instr_id = i; bus0.instr_valid = v; bus0.stall = st;
        bus0.flush = fl;   bus0.zero_id = z;     bus0.flags_ex = fx;
        bus1.instr_id = i; bus1.instr_valid = v; bus1.stall = st;
        bus1.flush = fl;   bus1.zero_id = z;     bus1.flags_ex = fx;
    endtask

    // Drive one vector, check the ID outputs, then check the EX slot after the edge
    task automatic step(input vec_t t, input int sel, input int idx);
        exp_t e;
        set_in(t.instr, t.v, t.st, t.fl, t.z, t.fx);
        #1;
        chk("id_out", idx, 32'(act_id(sel)), 32'(t.idout));
        e.ctl = t.ctl; e.nzcv = t.nzcv; e.ill = t.ill; e.sel = sel; e.idx = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("ctl", e.idx, 32'(act_ctl(e.sel)), 32'(e.ctl));
        chk("nzcv", e.idx, 32'(act_nzcv(e.sel)), 32'(e.nzcv));
        chk("ill_count", e.idx, 32'(act_ill(e.sel)), 32'(e.ill));
    endtask

    task automatic do_reset();
        set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_ctl", s, 32'(act_ctl(s)), 32'(BUB));
            chk("rst_nzcv", s, 32'(act_nzcv(s)), 32'h0);
            chk("rst_ill", s, 32'(act_ill(s)), 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        BUB   = cw(1'b0, 2'b00, 3'b010, 7'b0000000);
        NOPW  = cw(1'b1, 2'b00, 3'b010, 7'b0000000);
        ILLW  = cw(1'b1, 2'b00, 3'b010, 7'b0000001);
        ADDSW = cw(1'b1, 2'b00, 3'b010, 7'b0100010);
        SUBSW = cw(1'b1, 2'b00, 3'b011, 7'b0100010);
        CBW   = cw(1'b1, 2'b00, 3'b000, 7'b0000000);
        LDURW = cw(1'b1, 2'b01, 3'b010, 7'b1100000);
        STURW = cw(1'b1, 2'b01, 3'b010, 7'b0010000);
        LSLW  = cw(1'b1, 2'b00, 3'b010, 7'b0101100);
        LSRW  = cw(1'b1, 2'b00, 3'b010, 7'b0101000);
        ANDW  = cw(1'b1, 2'b00, 3'b100, 7'b0100000);
        ORRW  = cw(1'b1, 2'b00, 3'b101, 7'b0100000);
        EORW  = cw(1'b1, 2'b00, 3'b110, 7'b0100000);
        ADDIW = cw(1'b1, 2'b10, 3'b010, 7'b0100000);
        SUBIW = cw(1'b1, 2'b10, 3'b011, 7'b0100000);

        // Full-B.cond instance: instr, v, st, fl, z, flags_ex, {r2l,tk,un}, ctl, nzcv, ill
        tbl.push_back(mk(I_SUBS,        1,0,0,0, 4'hF, 3'b100, SUBSW, 4'h0, 8'd0));
        tbl.push_back(mk(I_BC | 32'd11, 1,0,0,0, 4'h8, 3'b010, NOPW,  4'h8, 8'd0));
        tbl.push_back(mk(I_ADDS,        1,0,0,0, 4'hF, 3'b100, ADDSW, 4'h8, 8'd0));
        tbl.push_back(mk(32'h0,         0,0,0,0, 4'h6, 3'b000, BUB,   4'h6, 8'd0));
        tbl.push_back(mk(32'h0,         0,0,0,0, 4'hF, 3'b000, BUB,   4'h6, 8'd0));
        tbl.push_back(mk(I_BC | 32'd0,  1,0,0,0, 4'hF, 3'b010, NOPW,  4'h6, 8'd0));
        tbl.push_back(mk(I_BC | 32'd1,  1,0,0,0, 4'hF, 3'b000, NOPW,  4'h6, 8'd0));
        tbl.push_back(mk(I_BC | 32'd8,  1,0,0,0, 4'hF, 3'b000, NOPW,  4'h6, 8'd0));
        tbl.push_back(mk(I_BC | 32'd9,  1,0,0,0, 4'hF, 3'b010, NOPW,  4'h6, 8'd0));
        tbl.push_back(mk(I_BC | 32'd10, 1,0,0,0, 4'hF, 3'b010, NOPW,  4'h6, 8'd0));
        tbl.push_back(mk(I_BC | 32'd11, 1,0,0,0, 4'hF, 3'b000, NOPW,  4'h6, 8'd0));
        tbl.push_back(mk(I_BC | 32'd12, 1,0,0,0, 4'hF, 3'b000, NOPW,  4'h6, 8'd0));
        tbl.push_back(mk(I_BC | 32'd13, 1,0,0,0, 4'hF, 3'b010, NOPW,  4'h6, 8'd0));
        tbl.push_back(mk(I_BC | 32'd14, 1,0,0,0, 4'hF, 3'b010, NOPW,  4'h6, 8'd0));
        tbl.push_back(mk(I_BC | 32'd15, 1,0,0,0, 4'hF, 3'b010, NOPW,  4'h6, 8'd0));
        tbl.push_back(mk(I_BC4,         1,0,0,0, 4'hF, 3'b000, ILLW,  4'h6, 8'd1));
        tbl.push_back(mk(I_CBZ,         1,1,0,1, 4'hF, 3'b000, BUB,   4'h6, 8'd1));
        tbl.push_back(mk(I_CBZ,         1,0,0,1, 4'hF, 3'b010, CBW,   4'h6, 8'd1));
        tbl.push_back(mk(I_CBNZ,        1,0,0,1, 4'hF, 3'b000, CBW,   4'h6, 8'd1));
        tbl.push_back(mk(I_CBNZ,        1,0,0,0, 4'hF, 3'b010, CBW,   4'h6, 8'd1));
        tbl.push_back(mk(I_B,           1,0,0,0, 4'hF, 3'b011, NOPW,  4'h6, 8'd1));
        tbl.push_back(mk(I_B,           1,0,1,0, 4'hF, 3'b001, BUB,   4'h6, 8'd1));
        tbl.push_back(mk(I_LDUR,        1,0,0,0, 4'hF, 3'b000, LDURW, 4'h6, 8'd1));
        tbl.push_back(mk(I_LDUR,        1,0,1,0, 4'hF, 3'b000, BUB,   4'h6, 8'd1));
        tbl.push_back(mk(I_STUR,        1,0,0,0, 4'hF, 3'b000, STURW, 4'h6, 8'd1));
        tbl.push_back(mk(I_LSL,         1,0,0,0, 4'hF, 3'b000, LSLW,  4'h6, 8'd1));
        tbl.push_back(mk(I_LSR,         1,0,0,0, 4'hF, 3'b000, LSRW,  4'h6, 8'd1));
        tbl.push_back(mk(I_AND,         1,0,0,0, 4'hF, 3'b100, ANDW,  4'h6, 8'd1));
        tbl.push_back(mk(I_ORR,         1,0,0,0, 4'hF, 3'b100, ORRW,  4'h6, 8'd1));
        tbl.push_back(mk(I_EOR,         1,0,0,0, 4'hF, 3'b100, EORW,  4'h6, 8'd1));
        tbl.push_back(mk(I_ADDI,        1,0,0,0, 4'hF, 3'b000, ADDIW, 4'h6, 8'd1));
        tbl.push_back(mk(I_SUBI,        1,0,0,0, 4'hF, 3'b000, SUBIW, 4'h6, 8'd1));
        tbl.push_back(mk(32'h0,         1,1,0,0, 4'hF, 3'b000, BUB,   4'h6, 8'd1));
        tbl.push_back(mk(I_BAD,         1,0,0,0, 4'hF, 3'b000, ILLW,  4'h6, 8'd2));
        tbl.push_back(mk(I_ADDS,        1,1,1,0, 4'hF, 3'b100, BUB,   4'h6, 8'd2));
        tbl.push_back(mk(I_SUBS,        1,0,0,0, 4'hF, 3'b100, SUBSW, 4'h6, 8'd2));
        tbl.push_back(mk(I_BC | 32'd0,  1,0,0,0, 4'h0, 3'b000, NOPW,  4'h0, 8'd2));

        // LT-only instance without CBNZ
        tb_lt.push_back(mk(I_BC | 32'd0,  1,0,0,0, 4'hF, 3'b000, ILLW,  4'h0, 8'd1));
        tb_lt.push_back(mk(I_SUBS,        1,0,0,0, 4'hF, 3'b100, SUBSW, 4'h0, 8'd1));
        tb_lt.push_back(mk(I_BC | 32'd11, 1,0,0,0, 4'h8, 3'b010, NOPW,  4'h8, 8'd1));
        tb_lt.push_back(mk(I_CBNZ,        1,0,0,0, 4'hF, 3'b000, ILLW,  4'h8, 8'd2));
        tb_lt.push_back(mk(I_BC | 32'd10, 1,0,0,0, 4'hF, 3'b000, ILLW,  4'h8, 8'd3));
        tb_lt.push_back(mk(I_CBZ,         1,0,0,1, 4'hF, 3'b010, CBW,   4'h8, 8'd3));

        do_reset();
        foreach (tbl[k]) step(tbl[k], 0, k);

        do_reset();
        foreach (tb_lt[k]) step(tb_lt[k], 1, 100 + k);
        for (int n = 0; n < 300; n++) begin
            set_in(I_BAD, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);
            @(posedge clk);
            #1;
        end
        chk("ill_sat_lt", 200, 32'(bus1.ill_count), 32'd255);
        chk("ill_sat_full", 201, 32'(bus0.ill_count), 32'd255);
        step(mk(I_BAD, 1,0,0,0, 4'hF, 3'b000, ILLW, 4'h8, 8'd255), 1, 202);

        // Reset asserted while a flag setter occupies EX
        do_reset();
        step(mk(I_ADDS, 1,0,0,0, 4'hF, 3'b100, ADDSW, 4'h0, 8'd0), 0, 300);
        step(mk(I_ADDS, 1,0,0,0, 4'h5, 3'b100, ADDSW, 4'h5, 8'd0), 0, 301);
        set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_ctl", 302, 32'(act_ctl(0)), 32'(BUB));
        chk("async_nzcv", 302, 32'(act_nzcv(0)), 32'h0);
        chk("async_ill", 302, 32'(act_ill(0)), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step(mk(I_SUBS, 1,0,0,0, 4'hF, 3'b100, SUBSW, 4'h0, 8'd0), 0, 303);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_decode_ctrl_unit
`default_nettype wire
